adc_uart_reporter: RTL and testbench

// - Downstream of the SPI ADC master controller.
// - Accepts each 16-bit ADC sample, plus its valid strobe, that the controller produces.
// - Formats the sample as 4 upper-case ASCII hex digits followed by CR LF.
// - Serialises the 6-char frame on a UART TX line (8N1, LSB first).
// - Sits between the ADC readout FSM and the board UART pin; the FSM is never stalled.

---
 rtl/adc_uart_reporter_pkg.sv | 21 ++
 rtl/adc_uart_reporter_if.sv | 14 +
 rtl/adc_uart_reporter_tx.sv | 68 ++++++
 rtl/adc_uart_reporter.sv | 106 ++++++++++
 tb/tb_adc_uart_reporter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_uart_reporter_pkg.sv
// Shared constants, state types and the hex-digit formatter for the ADC UART reporter.
package adc_uart_reporter_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_M10 = 8'h37;
  localparam int         FRAME_CHARS = 6;

  // Character sequencer: wait for a sample, present one char, wait for the byte to finish.
  typedef enum logic [1:0] {FR_IDLE, FR_LOAD, FR_SEND} frame_state_e;

  // Byte serialiser: START / DATA / STOP, each bit lasting CLKS_PER_BIT cycles.
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // Upper-case ASCII for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? ASCII_0 + {4'h0, n} : ASCII_A_M10 + {4'h0, n};
  endfunction

endpackage

// File: rtl/adc_uart_reporter_if.sv
// Sample input and UART/status outputs of the reporter, bundled for port connection.
interface adc_uart_reporter_if;
  logic [15:0] sample_in;
  logic        sample_vld;
  logic        uart_txd;
  logic        busy;
  logic        frame_done;
  logic [7:0]  overrun_cnt;

  modport master (output sample_in, sample_vld,
                  input  uart_txd, busy, frame_done, overrun_cnt);
  modport slave  (input  sample_in, sample_vld,
                  output uart_txd, busy, frame_done, overrun_cnt);
endinterface

// File: rtl/adc_uart_reporter_tx.sv
// 8N1 byte serialiser (LSB first). byte_rdy is high when idle and in the final
// cycle of the stop bit, so the sequencer learns of completion without a dead cycle.
module uart_tx_byte
  import adc_uart_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       SBCLKi,
  input  logic       RST_N,
  input  logic [7:0] byte_in,
  input  logic       byte_vld,
  output logic       byte_rdy,
  output logic       txd
);

  tx_state_e   r_st, w_st_nxt;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_byte;
  logic        w_tick;

  assign w_tick = (r_cnt == 16'(CLKS_PER_BIT - 1));

  // state register
  always_ff @(posedge SBCLKi or negedge RST_N)
    if (!RST_N) r_st <= TX_IDLE;
    else        r_st <= w_st_nxt;

  // next-state: each bit period ends on the baud tick
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      TX_IDLE:  if (byte_vld) w_st_nxt = TX_START;
      TX_START: if (w_tick) w_st_nxt = TX_DATA;
      TX_DATA:  if (w_tick && r_bit == 3'd7) w_st_nxt = TX_STOP;
      TX_STOP:  if (w_tick) w_st_nxt = byte_vld ? TX_START : TX_IDLE;
      default:  w_st_nxt = TX_IDLE;
    endcase
  end

  // outputs: line level and ready, decoded from state so reset forces the line high at once
  always_comb begin
    txd      = 1'b1;
    byte_rdy = 1'b0;
    case (r_st)
      TX_IDLE:  byte_rdy = 1'b1;
      TX_START: txd      = 1'b0;
      TX_DATA:  txd      = r_byte[r_bit];
      TX_STOP:  byte_rdy = w_tick;
      default:  ;
    endcase
  end

  // baud counter (restarts on every state entry and every bit), bit index, byte latch
  always_ff @(posedge SBCLKi or negedge RST_N)
    if (!RST_N) begin
      r_cnt  <= '0;
      r_bit  <= '0;
      r_byte <= '0;
    end else begin
      if (w_tick || w_st_nxt != r_st) r_cnt <= '0;
      else if (r_st != TX_IDLE)       r_cnt <= r_cnt + 16'd1;
      if (r_st != TX_DATA) r_bit <= '0;
      else if (w_tick)     r_bit <= r_bit + 3'd1;
      if (byte_rdy && byte_vld) r_byte <= byte_in;
    end

endmodule

// File: rtl/adc_uart_reporter.sv
// ADC sample -> "HHHH\r\n" UART reporter. One holding register decouples the
// ADC readout from the UART so the readout is never stalled; overwrites are counted.
module adc_uart_reporter
  import adc_uart_reporter_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [15:0] DATA_MASK    = 16'h0FFF
) (
  input  logic               SBCLKi,
  input  logic               RST_N,
  adc_uart_reporter_if.slave bus
);

  frame_state_e r_st, w_st_nxt;
  logic [15:0]  r_hold_q, r_frame_q;
  logic         r_hold_full, r_busy;
  logic [2:0]   r_char_idx;
  logic [7:0]   r_ovr, w_char;
  logic         w_consume, w_last_char, w_byte_vld, w_byte_rdy, w_frame_done, w_txd;

  assign w_consume   = (r_st == FR_IDLE) && r_hold_full;
  assign w_last_char = (r_char_idx == 3'(FRAME_CHARS - 1));

  // holding register and saturating overrun counter; a capture coinciding with consume is not an overrun
  always_ff @(posedge SBCLKi or negedge RST_N)
    if (!RST_N) begin
      r_hold_q    <= '0;
      r_hold_full <= 1'b0;
      r_ovr       <= '0;
    end else begin
      if (bus.sample_vld) begin
        r_hold_q    <= bus.sample_in & DATA_MASK;
        r_hold_full <= 1'b1;
        if (r_hold_full && !w_consume && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
      end else if (w_consume) begin
        r_hold_full <= 1'b0;
      end
    end

  // char formatter: four hex digits then CR LF
  always_comb begin
    w_char = ASCII_LF;
    case (r_char_idx)
      3'd0:    w_char = hex_ascii(r_frame_q[15:12]);
      3'd1:    w_char = hex_ascii(r_frame_q[11:8]);
      3'd2:    w_char = hex_ascii(r_frame_q[7:4]);
      3'd3:    w_char = hex_ascii(r_frame_q[3:0]);
      3'd4:    w_char = ASCII_CR;
      default: w_char = ASCII_LF;
    endcase
  end

  // sequencer state register
  always_ff @(posedge SBCLKi or negedge RST_N)
    if (!RST_N) r_st <= FR_IDLE;
    else        r_st <= w_st_nxt;

  // sequencer next-state
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      FR_IDLE: if (r_hold_full) w_st_nxt = FR_LOAD;
      FR_LOAD: w_st_nxt = FR_SEND;
      FR_SEND: if (w_byte_rdy) w_st_nxt = w_last_char ? FR_IDLE : FR_LOAD;
      default: w_st_nxt = FR_IDLE;
    endcase
  end

  // sequencer outputs: hand the byte over in LOAD, flag the end of the LF stop bit
  always_comb begin
    w_byte_vld   = (r_st == FR_LOAD);
    w_frame_done = (r_st == FR_SEND) && w_byte_rdy && w_last_char;
  end

  // frame latch, char index and busy flag
  always_ff @(posedge SBCLKi or negedge RST_N)
    if (!RST_N) begin
      r_frame_q  <= '0;
      r_char_idx <= '0;
      r_busy     <= 1'b0;
    end else begin
      if (w_consume) begin
        r_frame_q  <= r_hold_q;
        r_char_idx <= '0;
        r_busy     <= 1'b1;
      end else if (r_st == FR_SEND && w_byte_rdy && !w_last_char) begin
        r_char_idx <= r_char_idx + 3'd1;
      end
      if (w_frame_done) r_busy <= 1'b0;
    end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .SBCLKi   (SBCLKi),
    .RST_N    (RST_N),
    .byte_in  (w_char),
    .byte_vld (w_byte_vld),
    .byte_rdy (w_byte_rdy),
    .txd      (w_txd)
  );

  assign bus.uart_txd    = w_txd;
  assign bus.busy        = r_busy;
  assign bus.frame_done  = w_frame_done;
  assign bus.overrun_cnt = r_ovr;

endmodule

// File: tb/tb_adc_uart_reporter.sv
// Bench for adc_uart_reporter: cycle-level waveform model built from the frame
// text, a UART receiver for literal byte checks, directed cases plus random traffic.
module tb_adc_uart_reporter;

  localparam int CPB = 4;

  logic clk, rst_n;
  int   checks = 0;
  int   errs   = 0;
  bit   chk_en = 0;

  adc_uart_reporter_if bus ();

  adc_uart_reporter #(.CLKS_PER_BIT(CPB), .DATA_MASK(16'h0FFF)) dut (
    .SBCLKi (clk),
    .RST_N  (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Queue of expected {txd,busy,frame_done} per cycle while a frame is on the wire.
  logic [2:0]  mq[$];
  bit          mhold_full;
  logic [15:0] mhold;
  int          movr;

  function automatic logic [7:0] asc(input logic [3:0] d);
    if (d < 4'd10) return 8'(8'd48 + 8'(d));
    return 8'(8'd65 + 8'(d) - 8'd10);
  endfunction

  task automatic push_frame(input logic [15:0] v);
    logic [7:0] ch[6];
    logic [2:0] t;
    ch[0] = asc(v[15:12]); ch[1] = asc(v[11:8]);
    ch[2] = asc(v[7:4]);   ch[3] = asc(v[3:0]);
    ch[4] = 8'd13;         ch[5] = 8'd10;
    for (int c = 0; c < 6; c++) begin
      mq.push_back(3'b110);                         // one idle-level gap cycle per char
      repeat (CPB) mq.push_back(3'b010);            // start bit
      for (int b = 0; b < 8; b++)
        repeat (CPB) mq.push_back({ch[c][b], 2'b10});
      repeat (CPB) mq.push_back(3'b110);            // stop bit
    end
    t = mq.pop_back();
    t[0] = 1'b1;
    mq.push_back(t);
  endtask

  initial begin
    bit          idle, cons;
    logic [15:0] old;
    mhold_full = 0; mhold = '0; movr = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        mhold_full = 0;
        movr       = 0;
      end else begin
        idle = (mq.size() == 0);
        if (!idle) void'(mq.pop_front());
        cons = idle && mhold_full;
        old  = mhold;
        if (bus.sample_vld) begin
          if (mhold_full && !cons && movr < 255) movr++;
          mhold      = bus.sample_in & 16'h0FFF;
          mhold_full = 1;
        end else if (cons) begin
          mhold_full = 0;
        end
        if (cons) push_frame(old);
      end
    end
  end

  // per-cycle comparison of all outputs against the model
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e = (mq.size() != 0) ? mq[0] : 3'b100;
        checks++;
        if ({bus.uart_txd, bus.busy, bus.frame_done} !== e || bus.overrun_cnt !== 8'(movr)) begin
          errs++;
          $display("FAIL cycle_cmp t=%0t got txd/busy/fd=%b ovr=%0d want %b ovr=%0d",
                   $time, {bus.uart_txd, bus.busy, bus.frame_done}, bus.overrun_cnt, e, movr);
        end
      end
    end
  end

  // ---------------- UART receiver ----------------
  logic [7:0] rxq[$];

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && bus.uart_txd == 1'b0) begin
        repeat (CPB + 1) @(negedge clk);
        b[0] = bus.uart_txd;
        for (int k = 1; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = bus.uart_txd;
        end
        repeat (CPB) @(negedge clk);
        rxq.push_back(b);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic check_rx(input string nm, input logic [47:0] e);
    logic [47:0] got;
    got = '0;
    checks++;
    if (rxq.size() < 6) begin
      errs++;
      $display("FAIL %s: got %0d bytes want 6 bytes %h", nm, rxq.size(), e);
      rxq.delete();
    end else begin
      for (int i = 0; i < 6; i++) got = {got[39:0], rxq.pop_front()};
      if (got !== e) begin
        errs++;
        $display("FAIL %s: got %h want %h", nm, got, e);
      end
    end
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] v);
    bus.sample_in  = v;
    bus.sample_vld = 1'b1;
    @(posedge clk);
    #2;
    bus.sample_vld = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st, fdi;
    rst_n = 1; bus.sample_in = '0; bus.sample_vld = 1'b0;
    #1 rst_n = 0;
    chk_en = 1;
    repeat (5) @(posedge clk);
    #2;
    chk("reset_txd", 32'(bus.uart_txd), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_ovr", 32'(bus.overrun_cnt), 32'd0);
    rst_n = 1;
    idle_cyc(3);

    // single sample: latency and frame length
    send(16'hFABC);
    st = -1; fdi = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (st < 0 && bus.uart_txd == 1'b0) st = i;
      if (fdi < 0 && bus.frame_done) fdi = i;
    end
    idle_cyc(1);
    chk("start_latency", 32'(st), 32'd2);
    chk("frame_done_dist", 32'(fdi - st), 32'd244);
    check_rx("frame_FABC", 48'h30_41_42_43_0D_0A);

    // hex digit boundaries
    send(16'h0000); idle_cyc(260); check_rx("frame_0000", 48'h30_30_30_30_0D_0A);
    send(16'h0FFF); idle_cyc(260); check_rx("frame_0FFF", 48'h30_46_46_46_0D_0A);
    send(16'h09A0); idle_cyc(260); check_rx("frame_09A0", 48'h30_39_41_30_0D_0A);

    // capture coinciding with consume
    bus.sample_in = 16'h0111; bus.sample_vld = 1'b1;
    @(posedge clk); #2;
    bus.sample_in = 16'h0222;
    @(posedge clk); #2;
    bus.sample_vld = 1'b0;
    idle_cyc(520);
    chk("simul_ovr", 32'(bus.overrun_cnt), 32'd0);
    check_rx("simul_first", 48'h30_31_31_31_0D_0A);
    check_rx("simul_second", 48'h30_32_32_32_0D_0A);

    // hold and overwrite
    send(16'h0123); idle_cyc(20);
    send(16'h0456); idle_cyc(10);
    send(16'h0789); idle_cyc(520);
    chk("overrun_one", 32'(bus.overrun_cnt), 32'd1);
    check_rx("hold_first", 48'h30_31_32_33_0D_0A);
    check_rx("hold_second", 48'h30_37_38_39_0D_0A);

    // saturation
    bus.sample_vld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.sample_in = 16'($urandom);
      @(posedge clk); #2;
    end
    bus.sample_vld = 1'b0;
    chk("overrun_sat", 32'(bus.overrun_cnt), 32'hFF);
    idle_cyc(520);
    rxq.delete();

    // reset during DATA of char 2, with a sample waiting in hold
    send(16'h0AAA); idle_cyc(92);
    send(16'h0555);
    rst_n = 0;
    #1;
    chk("midrst_txd", 32'(bus.uart_txd), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    idle_cyc(5);
    rst_n = 1;
    idle_cyc(60);
    rxq.delete();
    send(16'h0321); idle_cyc(260);
    check_rx("after_reset", 48'h30_33_32_31_0D_0A);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.sample_vld = ($urandom_range(0, 199) < 3);
      bus.sample_in  = 16'($urandom);
      @(posedge clk); #2;
    end
    bus.sample_vld = 1'b0;
    idle_cyc(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
